// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver with start-bit glitch rejection and framing-error flag
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_rx,
    input  logic            i_s_tick,
    output logic [DBIT-1:0] o_dout,
    output logic            o_rx_done,
    output logic            o_frame_err,
    output logic            o_rx_busy
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    // Tick counter widens only when the stop period exceeds 16 ticks (1.5 / 2 stop bits)
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     s_q, s_d;
    logic [NW-1:0]     n_q, n_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic [DBIT-1:0]   dout_q, dout_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic              rx_meta_q, rx_meta_d;
    logic              rx_s_q, rx_s_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            s_q       <= '0;
            n_q       <= '0;
            b_q       <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            b_q       <= b_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
        end
    end

    always_comb begin
        rx_meta_d = i_rx;
        rx_s_d    = rx_meta_q;
        state_d   = state_q;
        s_d       = s_q;
        n_d       = n_q;
        b_d       = b_q;
        dout_d    = dout_q;
        ferr_d    = ferr_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Falling edge is acted on immediately so the start-bit midpoint is tick-aligned
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (i_s_tick) begin
                    if (s_q == SW'(7)) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (i_s_tick) begin
                    if (s_q == SW'(15)) begin
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        s_d = '0;
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (i_s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        dout_d  = b_q;
                        ferr_d  = ~rx_s_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_dout      = dout_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;
    assign o_rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized scoreboard bench for uart_rx at 64 clk per bit
module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       i_rx;
    logic       i_s_tick;
    logic [7:0] o_dout;
    logic       o_rx_done;
    logic       o_frame_err;
    logic       o_rx_busy;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    bit tick_en = 1'b1;
    int done_count = 0;
    bit prev_done = 1'b0;
    logic [7:0] last_sent = 8'h00;
    logic [8:0] exp_q[$];

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_rx       (i_rx),
        .i_s_tick   (i_s_tick),
        .o_dout     (o_dout),
        .o_rx_done  (o_rx_done),
        .o_frame_err(o_frame_err),
        .o_rx_busy  (o_rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick: one clk wide, every 4th clk, changed away from the active edge
    always @(negedge clk) begin
        tick_cnt = tick_cnt + 1;
        i_s_tick = tick_en && (tick_cnt % 4 == 0);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && o_rx_done) begin
            logic [8:0] e;
            done_count = done_count + 1;
            chk("done_single_cycle", int'(prev_done), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("dout", int'(o_dout), int'(e[7:0]));
                chk("frame_err", int'(o_frame_err), int'(e[8]));
                chk("busy_after_done", int'(o_rx_busy), 0);
            end
        end
        prev_done = reset && o_rx_done;
    end

    task automatic hold_bit(input logic v, input int clks);
        i_rx = v;
        repeat (clks) @(negedge clk);
    endtask

    // Stop bit 0 is only driven for part of the bit so the line is clearly idle again afterwards
    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int gap, input int gate_bit);
        exp_q.push_back({~stop_ok, data});
        last_sent = data;
        hold_bit(1'b0, 64);
        for (int i = 0; i < 8; i++) begin
            if (i == gate_bit) begin
                hold_bit(data[i], 32);
                tick_en = 1'b0;
                repeat (1000) @(negedge clk);
                chk("busy_while_gated", int'(o_rx_busy), 1);
                tick_en = 1'b1;
                hold_bit(data[i], 32);
            end else begin
                hold_bit(data[i], 64);
            end
        end
        if (stop_ok) begin
            hold_bit(1'b1, 64);
        end else begin
            hold_bit(1'b0, 48);
            hold_bit(1'b1, 16);
        end
        if (gap > 0) hold_bit(1'b1, gap);
    endtask

    initial begin
        int dc;
        logic [7:0] rd;
        bit sok;
        reset = 1'b0;
        i_rx  = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_dout", int'(o_dout), 0);
        chk("reset_done", int'(o_rx_done), 0);
        chk("reset_ferr", int'(o_frame_err), 0);
        chk("reset_busy", int'(o_rx_busy), 0);
        reset = 1'b1;
        repeat (40) @(negedge clk);

        send_frame(8'hA5, 1'b1, 64, -1);

        hold_bit(1'b0, 20);
        chk("glitch_busy", int'(o_rx_busy), 1);
        hold_bit(1'b1, 64);
        chk("glitch_idle", int'(o_rx_busy), 0);
        chk("glitch_dout", int'(o_dout), int'(last_sent));

        send_frame(8'h3C, 1'b0, 128, -1);
        send_frame(8'h81, 1'b1, 64, -1);

        // Abort 0xFF midway through data bit 3
        hold_bit(1'b0, 64);
        hold_bit(1'b1, 3 * 64 + 32);
        reset = 1'b0;
        #1;
        chk("async_rst_dout", int'(o_dout), 0);
        chk("async_rst_done", int'(o_rx_done), 0);
        chk("async_rst_ferr", int'(o_frame_err), 0);
        chk("async_rst_busy", int'(o_rx_busy), 0);
        @(negedge clk);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        last_sent = 8'h00;
        hold_bit(1'b1, 300);
        chk("post_rst_idle", int'(o_rx_busy), 0);
        chk("post_rst_dout", int'(o_dout), 0);
        send_frame(8'h12, 1'b1, 64, -1);

        dc = done_count;
        send_frame(8'h00, 1'b1, 0, -1);
        send_frame(8'hFF, 1'b1, 64, -1);
        chk("b2b_done_count", done_count - dc, 2);

        dc = done_count;
        send_frame(8'h6B, 1'b1, 64, 3);
        chk("gated_done_count", done_count - dc, 1);

        for (int k = 0; k < 24; k++) begin
            rd  = 8'($urandom_range(0, 255));
            sok = ($urandom_range(0, 4) != 0);
            send_frame(rd, sok, sok ? int'($urandom_range(0, 1)) * int'($urandom_range(0, 40)) : 128, -1);
        end

        repeat (200) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, default 8, number of data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16, oversampling ticks per stop bit (16 = 1 stop bit, 24 = 1.5 stop bits, 32 = 2 stop bits).
REQ-003 SHALL have port clk, input, 1 bit, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port i_rx, input, 1 bit, asynchronous serial line; idles high.
REQ-006 SHALL have port i_s_tick, input, 1 bit, one-clk-wide enable pulse at 16x the baud rate, from the baud generator.
REQ-007 SHALL have port o_dout, output, DBIT bits, last received data word.
REQ-008 SHALL have port o_rx_done, output, 1 bit, one-clk pulse marking that o_dout/o_frame_err are updated.
REQ-009 SHALL have port o_frame_err, output, 1 bit, stop-bit sample of the last frame was 0.
REQ-010 SHALL have port o_rx_busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL pass i_rx through a 2-flop synchronizer; all FSM decisions use only the second stage (rx_s).
REQ-012 SHALL implement FSM states IDLE, START, DATA and STOP; a 4-bit tick counter s; a bit counter n of width clog2(DBIT); and a DBIT-bit shift register b.
REQ-013 SHALL make s, n and state advance only in cycles with i_s_tick=1, except the IDLE->START transition.
REQ-014 In IDLE: when rx_s=0 (no tick required), SHALL go to START with s=0.
REQ-015 In START on a tick: if s=7 and rx_s=0, SHALL go to DATA with s=0 and n=0; if s=7 and rx_s=1, SHALL return to IDLE (glitch rejected, no done pulse); otherwise s=s+1.
REQ-016 In DATA on a tick: if s=15, SHALL shift rx_s into the MSB of b (LSB-first line order) and set s=0; then if n=DBIT-1 go to STOP, else n=n+1; otherwise s=s+1.
REQ-017 In STOP on a tick: if s=SB_TICK-1, SHALL load o_dout<=b, load o_frame_err<=~rx_s, pulse o_rx_done for exactly one clk, and go to IDLE; otherwise s=s+1.
REQ-018 o_rx_done SHALL be registered: high in the clk cycle after the final STOP tick edge, and low otherwise.
REQ-019 o_dout and o_frame_err SHALL hold their values between done pulses; a framing error SHALL still deliver the data word.
REQ-020 Back-to-back frames: the FSM SHALL be in IDLE the cycle after the final STOP tick and SHALL accept a start bit immediately.
REQ-021 i_rx activity while busy SHALL affect only the sampled bits; no restart of the current frame.
REQ-022 If i_s_tick stays low, the FSM SHALL hold its state indefinitely, with no timeout.

Reset
REQ-023 While reset=0: state=IDLE, s=0, n=0, b=0, both synchronizer flops=1, o_dout=0, o_rx_done=0, o_frame_err=0, o_rx_busy=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no done pulse and o_dout unchanged from its reset value; after release, the block SHALL wait in IDLE for a new falling edge.

Verification
REQ-025 Frame test: clk 100 MHz, tick every 4 clk, 64 clk/bit; send 0xA5 with 1 stop -> one o_rx_done pulse, o_dout=0xA5, o_frame_err=0, o_rx_busy low after done.
REQ-026 Glitch test: i_rx low for 5 ticks, then high -> return to IDLE, no o_rx_done, o_dout unchanged.
REQ-027 Framing test: send 0x3C with the stop bit driven 0 -> o_rx_done pulse, o_dout=0x3C, o_frame_err=1; next good frame 0x81 -> o_frame_err=0.
REQ-028 Reset test: assert reset during data bit 3 of 0xFF -> all outputs 0 immediately (async); release; send 0x12 -> o_dout=0x12.
REQ-029 Back-to-back test: 0x00 then 0xFF with no idle gap -> exactly two done pulses, values in order.
REQ-030 Tick-gating test: hold i_s_tick=0 for 1000 clk mid-DATA, then resume -> correct byte received, with no spurious done pulse.
